bsort100_core: RTL and testbench

- Self-contained bubble-sort accelerator for a fixed array of 100 signed 32-bit integers held in an internal register file.
- A start pulse sorts the array in place, ascending, then pulses done.
- A two-channel slave memory port lets the surrounding system (or a testbench) read the array, and write it while the block is idle.
- Sits as the top-level compute kernel behind a simple start/done handshake.

---
 rtl/bsort100_pkg.sv | 10 +
 rtl/bsort100_slave_if.sv | 47 ++++
 rtl/bsort100_core.sv | 117 +++++++++++
 tb/tb_bsort100_core.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bsort100_pkg.sv
// bsort100_pkg: shared widths, array size and FSM states for the bubble-sort core.
package bsort100_pkg;
  localparam int N_ELEMS = 100;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int BUS_W = 64;
  localparam int SIZE_W = 7;
  localparam int IDX_W = 7;
  typedef enum logic [2:0] {INIT, IDLE, PASS, PASS_END, DONE} state_e;
endpackage

// File: rtl/bsort100_slave_if.sv
// bsort100_slave_if: one slave channel -- address decode, registered read data and DataRdy.
module bsort100_slave_if
  import bsort100_pkg::*;
#(
  parameter int MEM_BASE = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     oe_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [BUS_W-1:0]         wdata_i,
  input  logic [SIZE_W-1:0]        size_i,
  input  logic signed [DATA_W-1:0] arr_i [N_ELEMS],
  output logic                     wr_en_o,
  output logic [IDX_W-1:0]         wr_idx_o,
  output logic [DATA_W-1:0]        wr_data_o,
  output logic [BUS_W-1:0]         rdata_o,
  output logic                     rdy_o
);
  localparam logic [ADDR_W-1:0] LO = ADDR_W'(MEM_BASE);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(MEM_BASE + N_ELEMS);
  logic hit;
  logic [ADDR_W-1:0] off;
  logic [BUS_W-1:0] rdata_d, rdata_q;
  logic rdy_q;
  logic unused_hi;
  assign hit = (oe_i | we_i) && addr_i >= LO && addr_i < HI;
  assign off = addr_i - LO;
  assign wr_idx_o = off[IDX_W-1:0];
  assign wr_data_o = wdata_i[DATA_W-1:0];
  // Writes narrower than a full word are acknowledged but never applied.
  assign wr_en_o = hit & we_i & (size_i == SIZE_W'(DATA_W));
  assign rdata_d = (hit & oe_i) ? {{(BUS_W-DATA_W){1'b0}}, arr_i[wr_idx_o]} : '0;
  assign unused_hi = ^{wdata_i[BUS_W-1:DATA_W], off[ADDR_W-1:IDX_W]};
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rdy_q <= hit;
    end
  end
  assign rdata_o = rdata_q;
  assign rdy_o = rdy_q;
endmodule

// File: rtl/bsort100_core.sv
// bsort100_core: in-place ascending bubble sort of 100 signed words with a 2-channel slave port.
// Define BSORT_EARLY_EXIT_EN to end the sort after the first pass with no swaps.
module bsort100_core
  import bsort100_pkg::*;
#(
  parameter int MEM_BASE = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_port,
  input  logic [1:0]            S_oe_ram,
  input  logic [1:0]            S_we_ram,
  input  logic [2*ADDR_W-1:0]   S_addr_ram,
  input  logic [2*BUS_W-1:0]    S_Wdata_ram,
  input  logic [2*SIZE_W-1:0]   S_data_ram_size,
  output logic                  done_port,
  output logic [2*BUS_W-1:0]    Sout_Rdata_ram,
  output logic [1:0]            Sout_DataRdy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEMS - 2);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, j_q, j_d, p_q, p_d;
  logic sw_q, sw_d, fin;
  logic signed [DATA_W-1:0] arr_q [N_ELEMS];
  logic signed [DATA_W-1:0] arr_d [N_ELEMS];
  logic signed [DATA_W-1:0] a, b;
  logic [1:0] wr_en;
  logic [IDX_W-1:0] wr_idx [2];
  logic [DATA_W-1:0] wr_data [2];
  for (genvar k = 0; k < 2; k++) begin : g_slave
    bsort100_slave_if #(.MEM_BASE(MEM_BASE)) u_slave (
      .clock     (clock),
      .reset     (reset),
      .oe_i      (S_oe_ram[k]),
      .we_i      (S_we_ram[k]),
      .addr_i    (S_addr_ram[k*ADDR_W +: ADDR_W]),
      .wdata_i   (S_Wdata_ram[k*BUS_W +: BUS_W]),
      .size_i    (S_data_ram_size[k*SIZE_W +: SIZE_W]),
      .arr_i     (arr_q),
      .wr_en_o   (wr_en[k]),
      .wr_idx_o  (wr_idx[k]),
      .wr_data_o (wr_data[k]),
      .rdata_o   (Sout_Rdata_ram[k*BUS_W +: BUS_W]),
      .rdy_o     (Sout_DataRdy[k])
    );
  end
  assign a = arr_q[j_q];
  assign b = arr_q[j_q + 1'b1];
`ifdef BSORT_EARLY_EXIT_EN
  assign fin = (p_q == LAST) || !sw_q;
`else
  assign fin = p_q == LAST;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    j_d = j_q;
    p_d = p_q;
    sw_d = sw_q;
    arr_d = arr_q;
    case (state_q)
      INIT: begin
        arr_d[idx_q] = ~DATA_W'(idx_q);
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IDX_W'(N_ELEMS - 1)) ? IDLE : INIT;
      end
      IDLE: begin
        // Channel 1 is applied last so it wins a same-address collision.
        if (wr_en[0]) arr_d[wr_idx[0]] = wr_data[0];
        if (wr_en[1]) arr_d[wr_idx[1]] = wr_data[1];
        if (start_port) begin
          sw_d = 1'b0;
          p_d = '0;
          j_d = '0;
          state_d = PASS;
        end
      end
      PASS: begin
        if (a > b) begin
          arr_d[j_q] = b;
          arr_d[j_q + 1'b1] = a;
          sw_d = 1'b1;
        end
        j_d = j_q + 1'b1;
        state_d = (j_q == LAST - p_q) ? PASS_END : PASS;
      end
      PASS_END: begin
        if (fin) state_d = DONE;
        else begin
          p_d = p_q + 1'b1;
          j_d = '0;
          sw_d = 1'b0;
          state_d = PASS;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      idx_q <= '0;
      j_q <= '0;
      p_q <= '0;
      sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      j_q <= j_d;
      p_q <= p_d;
      sw_q <= sw_d;
    end
    arr_q <= arr_d;
  end
  assign done_port = state_q == DONE;
endmodule

// File: tb/tb_bsort100_core.sv
// tb_bsort100_core: directed self-checking bench for bsort100_core.
module tb_bsort100_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_port = 1'b0;
  logic [1:0] S_oe_ram = '0;
  logic [1:0] S_we_ram = '0;
  logic [17:0] S_addr_ram = '0;
  logic [127:0] S_Wdata_ram = '0;
  logic [13:0] S_data_ram_size = '0;
  logic done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0] Sout_DataRdy;
  int total = 0;
  int bad = 0;
  logic signed [31:0] exp_arr [100];

  bsort100_core dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic access(input int ch, input logic rd, input logic [8:0] addr, input logic [31:0] data,
                        input logic [6:0] size, output logic [63:0] rdata, output logic rdy);
    S_oe_ram[ch] = rd;
    S_we_ram[ch] = !rd;
    S_addr_ram[ch*9 +: 9] = addr;
    S_Wdata_ram[ch*64 +: 64] = {32'b0, data};
    S_data_ram_size[ch*7 +: 7] = size;
    @(posedge clock);
    #1;
    rdata = Sout_Rdata_ram[ch*64 +: 64];
    rdy = Sout_DataRdy[ch];
    S_oe_ram[ch] = 1'b0;
    S_we_ram[ch] = 1'b0;
  endtask

  task automatic check_arr(input string tag);
    logic [63:0] d;
    logic r;
    for (int i = 0; i < 100; i++) begin
      access(0, 1'b1, 9'(128 + i), 32'd0, 7'd32, d, r);
      check($sformatf("%s_rdy[%0d]", tag, i), 64'(r), 64'd1);
      check($sformatf("%s[%0d]", tag, i), d, {32'b0, exp_arr[i]});
    end
  endtask

  task automatic start_sort();
    start_port = 1'b1;
    @(posedge clock);
    #1;
    start_port = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int n = 1; n <= 6000; n++) begin
      @(posedge clock);
      #1;
      if (done_port) begin
        cyc = n + 1;
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    logic r;
    int cyc;
    int hits;
    int exp_lat;
`ifdef BSORT_EARLY_EXIT_EN
    exp_lat = 101;
`else
    exp_lat = 5050;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("rst_done", 64'(done_port), 64'd0);
    check("rst_rdy", 64'(Sout_DataRdy), 64'd0);
    check("rst_rdata0", Sout_Rdata_ram[63:0], 64'd0);
    check("rst_rdata1", Sout_Rdata_ram[127:64], 64'd0);
    reset = 1'b0;
    repeat (105) @(posedge clock);
    #1;
    for (int i = 0; i < 100; i++) exp_arr[i] = -(i + 1);
    check_arr("init");

    start_sort();
    wait_done(cyc);
    check("lat_reverse", 64'(cyc), 64'd5050);
    @(posedge clock);
    #1;
    check("done_width", 64'(done_port), 64'd0);
    for (int i = 0; i < 100; i++) exp_arr[i] = i - 100;
    check_arr("sorted");

    start_sort();
    wait_done(cyc);
    check("lat_presorted", 64'(cyc), 64'(exp_lat));
    check_arr("resort");

    access(0, 1'b1, 9'd100, 32'd0, 7'd32, d, r);
    check("miss_rd_rdy", 64'(r), 64'd0);
    check("miss_rd_data", d, 64'd0);
    access(1, 1'b0, 9'd300, 32'd5, 7'd32, d, r);
    check("miss_wr_rdy", 64'(r), 64'd0);

    access(0, 1'b0, 9'd129, 32'd55, 7'd16, d, r);
    check("size16_rdy", 64'(r), 64'd1);
    access(0, 1'b1, 9'd129, 32'd0, 7'd32, d, r);
    check("size16_kept", d, {32'b0, exp_arr[1]});

    access(0, 1'b0, 9'd130, 32'd7, 7'd32, d, r);
    check("wr7_ch0_rdy", 64'(r), 64'd1);
    access(1, 1'b0, 9'd131, 32'd7, 7'd32, d, r);
    check("wr7_ch1_rdy", 64'(r), 64'd1);
    start_sort();
    access(0, 1'b0, 9'd128, 32'd999, 7'd32, d, r);
    check("busy_wr_rdy", 64'(r), 64'd1);
    wait_done(cyc);
    check("sevens_done", 64'(cyc != 0), 64'd1);
    for (int i = 0; i < 100; i++) exp_arr[i] = (i < 2) ? i - 100 : (i < 98) ? i - 98 : 7;
    check_arr("sevens");

    S_we_ram = 2'b11;
    S_addr_ram = {9'd140, 9'd140};
    S_Wdata_ram = {64'd22, 64'd11};
    S_data_ram_size = {7'd32, 7'd32};
    @(posedge clock);
    #1;
    check("dual_rdy", 64'(Sout_DataRdy), 64'd3);
    S_we_ram = 2'b00;
    access(1, 1'b1, 9'd140, 32'd0, 7'd32, d, r);
    check("dual_ch1_rd_rdy", 64'(r), 64'd1);
    check("dual_ch1_wins", d, 64'd22);

    hits = 0;
    start_sort();
    for (int n = 0; n < 1999; n++) begin
      @(posedge clock);
      #1;
      if (done_port) hits++;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      @(posedge clock);
      #1;
      if (done_port) hits++;
    end
    check("abort_no_done", 64'(hits), 64'd0);
    for (int i = 0; i < 100; i++) exp_arr[i] = -(i + 1);
    check_arr("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
